// File: rtl/riscv_pipe_pkg.sv
// +-----------------------------------------------------------------------------+
// | riscv_pipe_pkg                                                               |
// | Shared pipeline types and constants for the RISC-V fetch/decode boundary.    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

package riscv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

`default_nettype wire

// File: rtl/if_id_skid_buffer.sv
// +-----------------------------------------------------------------------------+
// | if_id_skid_buffer                                                            |
// | Two-entry valid/ready skid buffer between fetch and decode, with flush.      |
// | Optional stall counter enabled by defining IF_ID_STALL_CNT_EN.               |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module if_id_skid_buffer
    import riscv_pipe_pkg::*;
#(
    parameter int BITS       = 64,
    parameter int INSTR_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_pc,
    input  logic [INSTR_BITS-1:0] in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-1:0]       out_pc,
    output logic [INSTR_BITS-1:0] out_instr
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    localparam logic [INSTR_BITS-1:0] c_nop = INSTR_BITS'(NOP_INSTR);

    skid_state_t            r_state;
    skid_state_t            w_state_nxt;
    logic                   w_accept;
    logic                   w_issue;
    logic                   w_ld_main_in;
    logic                   w_ld_main_skid;
    logic                   w_ld_skid;
    logic                   w_clr;
    logic [BITS-1:0]        r_main_pc;
    logic [INSTR_BITS-1:0]  r_main_instr;
    logic [BITS-1:0]        r_skid_pc;
    logic [INSTR_BITS-1:0]  r_skid_instr;

    // Handshake flags decode straight from the state flop: no path from out_ready.
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_pc    = r_main_pc;
    assign out_instr = r_main_instr;

    assign w_accept = in_valid & in_ready;
    assign w_issue  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        w_clr          = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt  = ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && !w_issue) begin
                        w_state_nxt = FULL;
                        w_ld_skid   = 1'b1;
                    end else if (w_accept && w_issue) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_issue) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_issue) begin
                        w_state_nxt    = ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_pc    <= '0;
            r_main_instr <= c_nop;
        end else if (w_clr) begin
            r_main_pc    <= '0;
            r_main_instr <= c_nop;
        end else if (w_ld_main_in) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
        end else if (w_ld_main_skid) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_pc    <= '0;
            r_skid_instr <= c_nop;
        end else if (w_ld_skid) begin
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles where decode refuses a presented beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    // Stall counter not built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_buffer.sv
// +-----------------------------------------------------------------------------+
// | tb_if_id_skid_buffer                                                         |
// | Scoreboard bench for if_id_skid_buffer (stall checks with IF_ID_STALL_CNT_EN)|
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_if_id_skid_buffer;
    import riscv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int          total = 0;
    int          bad   = 0;
    if_id_t      q[$];
    logic [31:0] m_stall;

    always #5 clk = ~clk;

    if_id_skid_buffer #(.BITS(64), .INSTR_BITS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [63:0] pc);
        return pc[31:0] ^ 32'h5A5A_0033;
    endfunction

    // One clock cycle: drive, check against the queue model, update model, advance.
    task automatic cycle(input logic v, input logic [63:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = mk_instr(pc);
        out_ready = rdy;
        flush     = fl;
        #1;
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() > 0) begin
            check("out_pc", out_pc, q[0].pc);
            check("out_instr", {32'd0, out_instr}, {32'd0, q[0].instr});
        end
        if (out_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (out_valid && rdy && q.size() > 0) void'(q.pop_front());
        if (fl) q.delete();
        else if (v && in_ready) q.push_back('{pc: pc, instr: mk_instr(pc)});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_stall = '0;
    endtask

    initial begin
        do_reset();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'h13);

        // Streaming with decode always ready
        cycle(1'b1, 64'h0, 1'b1, 1'b0);
        cycle(1'b1, 64'h4, 1'b1, 1'b0);
        cycle(1'b1, 64'h8, 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);

        // Back-pressure fills both entries
        cycle(1'b1, 64'h10, 1'b0, 1'b0);
        cycle(1'b1, 64'h14, 1'b0, 1'b0);
        check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
        cycle(1'b1, 64'h18, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);

        // Flush with a same-cycle accept
        cycle(1'b1, 64'h20, 1'b0, 1'b0);
        cycle(1'b1, 64'h24, 1'b0, 1'b1);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_out_pc", out_pc, 64'd0);
        check("flush_out_instr", {32'd0, out_instr}, 64'h13);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);

        // Hold: out_* stable for ten refused cycles
        cycle(1'b1, 64'h30, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 64'h0, 1'b0, 1'b0);
        check("hold_pc", out_pc, 64'h30);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom % 4) != 0, 64'h1000 + 64'(i) * 4, ($urandom % 3) != 0,
                  ($urandom % 20) == 0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);
        check("drain_empty", {63'd0, out_valid}, 64'd0);

`ifdef IF_ID_STALL_CNT_EN
        do_reset();
        check("stall_rst", {32'd0, stall_cnt}, 64'd0);
        cycle(1'b1, 64'h40, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 64'h0, 1'b0, 1'b0);
        check("stall_7", {32'd0, stall_cnt}, 64'd7);
        check("stall_model", {32'd0, stall_cnt}, {32'd0, m_stall});
        force dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_cnt;
        m_stall = 32'hFFFF_FFFD;
        for (int i = 0; i < 4; i++) cycle(1'b0, 64'h0, 1'b0, 1'b0);
        check("stall_sat", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
        cycle(1'b0, 64'h0, 1'b0, 1'b1);
        check("stall_flush", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
        cycle(1'b0, 64'h0, 1'b1, 1'b0);
`endif

        // Asynchronous reset in the middle of a FULL cycle
        cycle(1'b1, 64'h50, 1'b0, 1'b0);
        cycle(1'b1, 64'h54, 1'b0, 1'b0);
        check("pre_rst_full", {63'd0, in_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_out_instr", {32'd0, out_instr}, 64'h13);
        check("arst_out_pc", out_pc, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
